// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data memory request/response bus between the access unit and memory
interface mem_access_unit_if #(
  parameter int XLEN = 32
);
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_we;
  logic [XLEN/8-1:0]   mem_be;
  logic [XLEN-1:0]     mem_addr;
  logic [XLEN-1:0]     mem_wdata;
  logic                mem_rsp_valid;
  logic [XLEN-1:0]     mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: sub-word loads/stores over a variable-latency data memory
// with misalignment/timeout faults, flush, and upstream stall while an access is outstanding.
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [1:0]      ex_size,
  input  logic            ex_unsigned,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic [RD_W-1:0] ex_rd,
  input  logic            ex_reg_write,
  input  logic            flush,
  output logic            stall_m,
  mem_access_unit_if.master mem,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr
);
  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_valid_q, req_valid_d;
  logic             we_q, we_d;
  logic [BE_W-1:0]  be_q, be_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic             regw_q, regw_d;
  logic             wb_valid_q, wb_valid_d;
  logic             wb_regw_q, wb_regw_d;
  logic [RD_W-1:0]  wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic             fault_q, fault_d;
  logic [XLEN-1:0]  fault_addr_q, fault_addr_d;

  logic             is_mem, misal, hs, timed_out;
  logic [BE_W-1:0]  be_base;
  logic [XLEN-1:0]  wdata_rep, ld_sh, ld_mask, ld_data;
  logic             ld_sign;

  always_comb begin
    misal     = 1'b0;
    be_base   = '0;
    wdata_rep = ex_wdata;
    case (ex_size)
      2'd0: begin
        be_base   = BE_W'(1);
        wdata_rep = {BE_W{ex_wdata[7:0]}};
      end
      2'd1: begin
        misal     = ex_addr[0];
        be_base   = BE_W'(2'b11);
        wdata_rep = {(BE_W/2){ex_wdata[15:0]}};
      end
      2'd2: begin
        misal     = |ex_addr[1:0];
        be_base   = BE_W'(4'hF);
        wdata_rep = {(BE_W/4){ex_wdata[31:0]}};
      end
      default: begin
        // Double-word accesses do not exist on a 32-bit datapath.
        misal     = (XLEN == 32) ? 1'b1 : |ex_addr[2:0];
        be_base   = '1;
        wdata_rep = ex_wdata;
      end
    endcase
  end

  always_comb begin
    ld_sh   = mem.mem_rdata >> {off_q, 3'b000};
    ld_mask = '1;
    ld_sign = ld_sh[XLEN-1];
    case (size_q)
      2'd0: begin ld_mask = XLEN'(8'hFF);         ld_sign = ld_sh[7];  end
      2'd1: begin ld_mask = XLEN'(16'hFFFF);      ld_sign = ld_sh[15]; end
      2'd2: begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_sign = ld_sh[31]; end
      default: begin ld_mask = '1; ld_sign = ld_sh[XLEN-1]; end
    endcase
    ld_data = (ld_sh & ld_mask) | ((ld_sign && !uns_q) ? ~ld_mask : '0);
  end

  assign is_mem    = ex_mem_read | ex_mem_write;
  assign hs        = req_valid_q && mem.mem_req_ready;
  assign timed_out = (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    req_valid_d  = req_valid_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    rd_d         = rd_q;
    regw_d       = regw_q;
    wb_valid_d   = 1'b0;
    wb_regw_d    = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid && !flush) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_regw_d  = ex_reg_write;
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_addr;
          end else if (misal) begin
            fault_d      = 1'b1;
            fault_addr_d = ex_addr;
          end else begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            we_d        = ex_mem_write;
            be_d        = be_base << ex_addr[OFF_W-1:0];
            addr_d      = {ex_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            wdata_d     = wdata_rep;
            off_d       = ex_addr[OFF_W-1:0];
            size_d      = ex_size;
            uns_d       = ex_unsigned;
            rd_d        = ex_rd;
            regw_d      = ex_reg_write;
          end
        end
      end
      S_REQ: begin
        if (flush) begin
          // A store that handshakes now is already committed; only a load needs draining.
          req_valid_d = 1'b0;
          state_d     = (hs && !we_q) ? S_DRAIN : S_IDLE;
        end else if (hs) begin
          req_valid_d = 1'b0;
          if (we_q) begin
            state_d    = S_IDLE;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
          end else begin
            state_d = S_WAIT;
          end
        end else if (timed_out) begin
          req_valid_d  = 1'b0;
          state_d      = S_IDLE;
          fault_d      = 1'b1;
          fault_addr_d = addr_q | XLEN'(off_q);
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = mem.mem_rsp_valid ? S_IDLE : S_DRAIN;
        end else if (mem.mem_rsp_valid) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b1;
          wb_regw_d  = regw_q;
          wb_rd_d    = rd_q;
          wb_data_d  = ld_data;
        end else if (timed_out) begin
          state_d      = S_IDLE;
          fault_d      = 1'b1;
          fault_addr_d = addr_q | XLEN'(off_q);
        end
      end
      default: begin
        if (mem.mem_rsp_valid || timed_out) state_d = S_IDLE;
      end
    endcase
    cnt_d = (state_q == S_IDLE || state_d == S_IDLE) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_valid_q  <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      rd_q         <= '0;
      regw_q       <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_regw_q    <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_valid_q  <= req_valid_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      rd_q         <= rd_d;
      regw_q       <= regw_d;
      wb_valid_q   <= wb_valid_d;
      wb_regw_q    <= wb_regw_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign stall_m           = (state_q != S_IDLE);
  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_we        = we_q;
  assign mem.mem_be        = be_q;
  assign mem.mem_addr      = addr_q;
  assign mem.mem_wdata     = wdata_q;
  assign wb_valid          = wb_valid_q;
  assign wb_reg_write      = wb_regw_q;
  assign wb_rd             = wb_rd_q;
  assign wb_data           = wb_data_q;
  assign fault             = fault_q;
  assign fault_addr        = fault_addr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - table-driven and sequence checks for mem_access_unit
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_unsigned, ex_reg_write, flush;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        stall_m, wb_valid, wb_reg_write, fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, fault_addr;

  int tests = 0;
  int fails = 0;

  mem_access_unit_if #(.XLEN(32)) bus ();

  mem_access_unit #(.XLEN(32), .RD_W(5), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .flush(flush), .stall_m(stall_m),
    .mem(bus),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, rd, wr;
    logic [1:0]  size;
    logic        uns, flush;
    logic [31:0] addr, wdata, rdata;
    logic [4:0]  rdi;
    logic        regw;
    logic        exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata;
    logic        exp_wbv;
    logic [31:0] exp_wb;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rdi);
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr; ex_size = sz; ex_unsigned = uns;
    ex_addr = addr; ex_wdata = wd; ex_rd = rdi; ex_reg_write = 1'b1;
  endtask

  initial begin
    int cyc;
    int stall_cnt;
    rst_n = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_size = 2'd0;
    ex_unsigned = 1'b0; ex_addr = '0; ex_wdata = '0; ex_rd = '0; ex_reg_write = 1'b0; flush = 1'b0;
    bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b0; bus.mem_rdata = '0;

    //            valid rd wr size uns fl  addr           wdata          rdata          rd  rw req be       maddr          mwdata         wbv wb             fault
    vecs[0]  = '{1, 0, 0, 2'd0, 0, 0, 32'h1234_5678, 32'h0,         32'h0,         5'd7, 1, 0, 4'b0000, 32'h0,         32'h0,         1, 32'h1234_5678, 0};
    vecs[1]  = '{1, 1, 0, 2'd0, 0, 0, 32'h0000_0103, 32'h0,         32'h80AA_BBCC, 5'd1, 1, 1, 4'b1000, 32'h0000_0100, 32'h0,         1, 32'hFFFF_FF80, 0};
    vecs[2]  = '{1, 1, 0, 2'd0, 1, 0, 32'h0000_0101, 32'h0,         32'h80AA_BBCC, 5'd2, 1, 1, 4'b0010, 32'h0000_0100, 32'h0,         1, 32'h0000_00BB, 0};
    vecs[3]  = '{1, 1, 0, 2'd1, 0, 0, 32'h0000_0402, 32'h0,         32'h8001_7FFF, 5'd3, 1, 1, 4'b1100, 32'h0000_0400, 32'h0,         1, 32'hFFFF_8001, 0};
    vecs[4]  = '{1, 1, 0, 2'd1, 1, 0, 32'h0000_0400, 32'h0,         32'h8001_F00D, 5'd4, 1, 1, 4'b0011, 32'h0000_0400, 32'h0,         1, 32'h0000_F00D, 0};
    vecs[5]  = '{1, 1, 0, 2'd1, 0, 0, 32'h0000_0400, 32'h0,         32'h0000_7FFF, 5'd5, 1, 1, 4'b0011, 32'h0000_0400, 32'h0,         1, 32'h0000_7FFF, 0};
    vecs[6]  = '{1, 1, 0, 2'd2, 0, 0, 32'h0000_0500, 32'h0,         32'hDEAD_BEEF, 5'd6, 1, 1, 4'b1111, 32'h0000_0500, 32'h0,         1, 32'hDEAD_BEEF, 0};
    vecs[7]  = '{1, 0, 1, 2'd0, 0, 0, 32'h0000_0601, 32'h1234_56A5, 32'h0,         5'd8, 1, 1, 4'b0010, 32'h0000_0600, 32'hA5A5_A5A5, 1, 32'h0,         0};
    vecs[8]  = '{1, 0, 1, 2'd2, 0, 0, 32'h0000_0704, 32'hCAFE_F00D, 32'h0,         5'd9, 1, 1, 4'b1111, 32'h0000_0704, 32'hCAFE_F00D, 1, 32'h0,         0};
    vecs[9]  = '{1, 1, 1, 2'd2, 0, 0, 32'h0000_0800, 32'h1122_3344, 32'h0,         5'd10,1, 1, 4'b1111, 32'h0000_0800, 32'h1122_3344, 1, 32'h0,         0};
    vecs[10] = '{1, 1, 0, 2'd1, 0, 0, 32'h0000_0901, 32'h0,         32'h0,         5'd11,1, 0, 4'b0000, 32'h0,         32'h0,         0, 32'h0,         1};
    vecs[11] = '{1, 1, 0, 2'd2, 0, 0, 32'h0000_0302, 32'h0,         32'h0,         5'd12,1, 0, 4'b0000, 32'h0,         32'h0,         0, 32'h0,         1};
    vecs[12] = '{1, 0, 0, 2'd0, 0, 1, 32'h0000_0AAA, 32'h0,         32'h0,         5'd13,1, 0, 4'b0000, 32'h0,         32'h0,         0, 32'h0,         0};
    vecs[13] = '{0, 1, 0, 2'd2, 0, 0, 32'h0000_0B00, 32'h0,         32'h0,         5'd14,1, 0, 4'b0000, 32'h0,         32'h0,         0, 32'h0,         0};
    vecs[14] = '{1, 0, 1, 2'd1, 0, 0, 32'h0000_0206, 32'h0000_BEEF, 32'h0,         5'd15,1, 1, 4'b1100, 32'h0000_0204, 32'hBEEF_BEEF, 1, 32'h0,         0};

    tick(); tick();
    check("rst_stall", stall_m, 0);
    check("rst_req_valid", bus.mem_req_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_fault", fault, 0);
    check("rst_be", bus.mem_be, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      ex_valid = vecs[i].valid; ex_mem_read = vecs[i].rd; ex_mem_write = vecs[i].wr;
      ex_size = vecs[i].size; ex_unsigned = vecs[i].uns; ex_addr = vecs[i].addr;
      ex_wdata = vecs[i].wdata; ex_rd = vecs[i].rdi; ex_reg_write = vecs[i].regw;
      flush = vecs[i].flush; bus.mem_req_ready = 1'b1;
      tick();
      ex_valid = 1'b0; flush = 1'b0;
      check($sformatf("v%0d_req_valid", i), bus.mem_req_valid, vecs[i].exp_req);
      check($sformatf("v%0d_stall", i), stall_m, vecs[i].exp_req);
      if (vecs[i].exp_req) begin
        check($sformatf("v%0d_be", i), bus.mem_be, vecs[i].exp_be);
        check($sformatf("v%0d_addr", i), bus.mem_addr, vecs[i].exp_addr);
        check($sformatf("v%0d_wdata", i), bus.mem_wdata, vecs[i].exp_wdata);
        check($sformatf("v%0d_we", i), bus.mem_we, vecs[i].wr);
        tick();
        if (!vecs[i].wr) begin
          check($sformatf("v%0d_wait_stall", i), stall_m, 1);
          bus.mem_rsp_valid = 1'b1; bus.mem_rdata = vecs[i].rdata;
          tick();
          bus.mem_rsp_valid = 1'b0;
          check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].exp_wb);
        end
        check($sformatf("v%0d_wb_regw", i), wb_reg_write, vecs[i].rd & ~vecs[i].wr);
        check($sformatf("v%0d_done_stall", i), stall_m, 0);
      end else if (vecs[i].exp_fault) begin
        check($sformatf("v%0d_fault_addr", i), fault_addr, vecs[i].addr);
      end else if (vecs[i].exp_wbv) begin
        check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].exp_wb);
        check($sformatf("v%0d_wb_regw", i), wb_reg_write, vecs[i].regw);
      end
      check($sformatf("v%0d_wb_valid", i), wb_valid, vecs[i].exp_wbv);
      check($sformatf("v%0d_fault", i), fault, vecs[i].exp_fault);
      if (vecs[i].exp_wbv) check($sformatf("v%0d_wb_rd", i), wb_rd, vecs[i].rdi);
      tick();
    end

    // Signed byte load, response two cycles after the handshake: three stall cycles.
    drive(1, 0, 2'd0, 0, 32'h103, 32'h0, 5'd20);
    bus.mem_req_ready = 1'b1;
    stall_cnt = 0;
    tick(); ex_valid = 1'b0;
    check("lb_be", bus.mem_be, 4'b1000);
    check("lb_addr", bus.mem_addr, 32'h100);
    for (int k = 0; k < 3; k++) begin
      if (stall_m) stall_cnt++;
      if (k == 2) begin bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h80AA_BBCC; end
      tick();
    end
    bus.mem_rsp_valid = 1'b0;
    check("lb_stall_cycles", stall_cnt, 3);
    check("lb_wb_valid", wb_valid, 1);
    check("lb_wb_data", wb_data, 32'hFFFF_FF80);
    check("lb_stall_after", stall_m, 0);

    // Store half with ready held off for four cycles.
    drive(0, 1, 2'd1, 0, 32'h202, 32'h1234_ABCD, 5'd21);
    bus.mem_req_ready = 1'b0;
    tick(); ex_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("sh_hold%0d_valid", k), bus.mem_req_valid, 1);
      check($sformatf("sh_hold%0d_be", k), bus.mem_be, 4'b1100);
      check($sformatf("sh_hold%0d_wdata", k), bus.mem_wdata, 32'hABCD_ABCD);
      check($sformatf("sh_hold%0d_wb_valid", k), wb_valid, 0);
      if (k == 4) bus.mem_req_ready = 1'b1;
      tick();
    end
    check("sh_wb_valid", wb_valid, 1);
    check("sh_wb_regw", wb_reg_write, 0);
    check("sh_req_dropped", bus.mem_req_valid, 0);
    tick();

    // Load that never gets a response times out.
    drive(1, 0, 2'd2, 0, 32'h1000, 32'h0, 5'd22);
    tick(); ex_valid = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (fault) begin cyc = k; break; end
      if (wb_valid) break;
    end
    check("to_cycles", cyc, 8);
    check("to_fault_addr", fault_addr, 32'h1000);
    check("to_wb_valid", wb_valid, 0);
    check("to_stall", stall_m, 0);
    drive(0, 0, 2'd0, 0, 32'h0000_ABCD, 32'h0, 5'd23);
    tick(); ex_valid = 1'b0;
    check("to_alu_wb_valid", wb_valid, 1);
    check("to_alu_wb_data", wb_data, 32'h0000_ABCD);
    tick();

    // Flush in WAIT, response three cycles later is drained.
    drive(1, 0, 2'd2, 0, 32'h1100, 32'h0, 5'd24);
    tick(); ex_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick(); flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("fw_d%0d_stall", k), stall_m, 1);
      check($sformatf("fw_d%0d_wb_valid", k), wb_valid, 0);
      if (k == 2) begin bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h5555_5555; end
      tick();
    end
    bus.mem_rsp_valid = 1'b0;
    check("fw_end_stall", stall_m, 0);
    check("fw_end_wb_valid", wb_valid, 0);
    bus.mem_rsp_valid = 1'b1;
    tick(); bus.mem_rsp_valid = 1'b0;
    check("idle_rsp_wb_valid", wb_valid, 0);
    check("idle_rsp_stall", stall_m, 0);

    // Flush in REQ before the handshake, then flush coinciding with a store handshake.
    drive(1, 0, 2'd2, 0, 32'h1200, 32'h0, 5'd25);
    bus.mem_req_ready = 1'b0;
    tick(); ex_valid = 1'b0;
    flush = 1'b1;
    tick(); flush = 1'b0;
    check("fr_req_valid", bus.mem_req_valid, 0);
    check("fr_stall", stall_m, 0);
    bus.mem_req_ready = 1'b1;
    drive(0, 1, 2'd2, 0, 32'h1300, 32'h1, 5'd26);
    tick(); ex_valid = 1'b0;
    flush = 1'b1;
    tick(); flush = 1'b0;
    check("fs_wb_valid", wb_valid, 0);
    check("fs_stall", stall_m, 0);

    // Reset while waiting for a response.
    drive(1, 0, 2'd2, 0, 32'h1400, 32'h0, 5'd27);
    tick(); ex_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("rw_stall", stall_m, 0);
    check("rw_req_valid", bus.mem_req_valid, 0);
    check("rw_we", bus.mem_we, 0);
    check("rw_addr", bus.mem_addr, 0);
    check("rw_wb_data", wb_data, 0);
    check("rw_wb_rd", wb_rd, 0);
    check("rw_fault_addr", fault_addr, 0);
    rst_n = 1'b1;
    bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h7777_7777;
    tick(); bus.mem_rsp_valid = 1'b0;
    check("rw_late_wb_valid", wb_valid, 0);
    drive(1, 0, 2'd2, 0, 32'h104, 32'h0, 5'd28);
    tick(); ex_valid = 1'b0;
    tick();
    bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h1122_3344;
    tick(); bus.mem_rsp_valid = 1'b0;
    check("rw_next_wb_valid", wb_valid, 1);
    check("rw_next_wb_data", wb_data, 32'h1122_3344);
    check("rw_next_wb_rd", wb_rd, 5'd28);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the single-cycle memory-access stage. Sits between EX/MEM and MEM/WB.
- Talks to a variable-latency data memory over a valid/ready request channel and a valid-only response channel.
- Handles sub-word loads/stores with byte enables and sign/zero extension, misalignment and timeout faults, and flush.
- Stalls the upstream pipeline while an access is outstanding.

Parameters:
XLEN, 32, data/address width; must be 32 or 64
RD_W, 5, destination register index width
TIMEOUT, 255, maximum cycles in REQ/WAIT/DRAIN before a bus fault is raised

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ex_valid  in  1  EX/MEM holds a valid instruction
ex_mem_read  in  1  instruction is a load
ex_mem_write  in  1  instruction is a store
ex_size  in  2  access size: 0 byte, 1 half, 2 word, 3 double (XLEN=64 only)
ex_unsigned  in  1  zero-extend the load result
ex_addr  in  XLEN  effective address (ALU result)
ex_wdata  in  XLEN  store data, in the low bits
ex_rd  in  RD_W  destination register
ex_reg_write  in  1  writes the register file
flush  in  1  kill the in-flight access and the current EX/MEM instruction
stall_m  out  1  upstream must hold its ex_* signals
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts the request
mem_we  out  1  request is a write
mem_be  out  XLEN/8  byte enables
mem_addr  out  XLEN  address, aligned to XLEN/8 bytes
mem_wdata  out  XLEN  write data, replicated across lanes
mem_rsp_valid  in  1  read data valid
mem_rdata  in  XLEN  read data
wb_valid  out  1  one-cycle pulse: result available
wb_reg_write  out  1  qualifies wb_rd/wb_data
wb_rd  out  RD_W  destination register
wb_data  out  XLEN  extended load data, or ex_addr for non-memory instructions
fault  out  1  one-cycle pulse: misalignment or timeout
fault_addr  out  XLEN  faulting address

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; timeout counter clears.
  - All outputs are 0, including stall_m, mem_req_valid, wb_valid and fault.
  - Reset mid-access abandons the access silently.
- States: IDLE, REQ, WAIT, DRAIN. stall_m = (state != IDLE). ex_* inputs are ignored outside IDLE.
- In IDLE, with ex_valid=1 and flush=0:
  - Non-memory instruction: next cycle wb_valid=1, wb_data=ex_addr, wb_rd and wb_reg_write copied. Latency 1, no stall.
  - Misaligned access (half with addr[0]≠0; word with addr[1:0]≠0; double with addr[2:0]≠0):
    - No request is issued.
    - Next cycle fault=1, fault_addr=ex_addr, wb_valid=0.
    - State stays IDLE.
  - Aligned memory access:
    - Latch operation, offset = addr mod (XLEN/8), size and rd.
    - Next cycle: state REQ, with mem_req_valid, mem_we, mem_be, mem_addr and mem_wdata registered and held stable until handshake.
  - ex_mem_read and ex_mem_write both set: treated as a store.
- Byte lanes:
  - mem_be = ((1 << 2^size) - 1) << offset.
  - mem_wdata = low 2^size bytes of ex_wdata replicated across XLEN.
- REQ:
  - Handshake when mem_req_valid && mem_req_ready.
  - Store: completes at the handshake. Next cycle state IDLE and wb_valid=1 with wb_reg_write=0.
  - Load: next cycle state WAIT, mem_req_valid=0.
- WAIT:
  - On mem_rsp_valid: data = mem_rdata >> (8*offset), truncated to 2^size bytes, then sign- or zero-extended to XLEN.
  - Next cycle: wb_valid=1, wb_data=data, state IDLE.
- mem_rsp_valid in IDLE or REQ is ignored.
- Timeout:
  - Counter runs in REQ, WAIT and DRAIN and clears on entry to IDLE.
  - When it reaches TIMEOUT without completion: next cycle fault=1, fault_addr=latched address, state IDLE, no wb_valid.
- flush (priority over everything except reset):
  - In IDLE: the current ex_* instruction is discarded.
  - In REQ before the handshake: drop mem_req_valid next cycle; go to IDLE.
  - In REQ with the handshake in the same cycle: a store is committed but no wb_valid is produced; a load goes to DRAIN.
  - In WAIT: go to DRAIN; if mem_rsp_valid arrives in the same cycle, it is consumed and discarded, and the state goes to IDLE.
  - DRAIN: wait for mem_rsp_valid (discarded), then IDLE; timeout applies but raises no fault.
- Ordering: one outstanding access at most; wb results leave in program order.

Test Plan:
- Load byte, signed: ex_addr=0x103, ex_size=0, ex_unsigned=0. Request: ready=1 immediately, mem_addr=0x100, mem_be=4'b1000. Response 2 cycles later with mem_rdata=0x80AA_BBCC -> wb_data=0xFFFF_FF80; stall_m high for 3 cycles.
- Store half: ex_addr=0x202, ex_wdata=0x1234_ABCD, ex_size=1, ready delayed 4 cycles -> mem_be=4'b1100, mem_wdata=0xABCD_ABCD stable for all 5 request cycles; wb_valid with wb_reg_write=0 one cycle after the handshake.
- Misaligned word load: ex_addr=0x302 -> no mem_req_valid; fault=1, fault_addr=0x302 for one cycle; stall_m stays 0.
- Timeout: TIMEOUT=8, load with mem_rsp_valid never asserted -> fault pulse 8 cycles after entering REQ; state returns to IDLE and a following ALU instruction writes back normally.
- Flush in WAIT, response 3 cycles later -> no wb_valid; stall_m stays high until the cycle after the response. Separately, mem_rsp_valid during IDLE -> no effect.
- Reset (rst_n=0) asserted while in WAIT -> next cycle all outputs 0; a late response is ignored; the next load completes normally.
